cic_comp_fir: RTL and testbench



---
 rtl/cic_comp_fir.sv | 146 ++++++++++++++
 tb/tb_cic_comp_fir.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR after the CIC decimator: one shared MAC walks the taps
// once per accepted sample. Optional `CIC_COMP_FIR_SAT_EN selects output clamping over wrap.
module cic_comp_fir #(
  parameter int NTAPS = 15,
  parameter int AW    = 4,
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int ACCW  = 40,
  parameter int SHIFT = 16
) (
  input  logic                 rf_clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] audio_in,
  input  logic                 in_valid,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic signed [DW-1:0] audio_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic [AW-1:0]          LAST    = AW'(NTAPS - 1);
  localparam logic signed [CW-1:0]   UNITY   = CW'(65536);
  localparam logic signed [ACCW-1:0] HALF    = ACCW'(1) <<< (SHIFT - 1);
  localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] OUT_MIN = -OUT_MAX - ACCW'(1);

  state_t state_q, state_d;

  logic signed [DW-1:0]   x_q    [NTAPS];
  logic signed [DW-1:0]   x_d    [NTAPS];
  logic signed [CW-1:0]   coef_q [NTAPS];
  logic signed [CW-1:0]   coef_d [NTAPS];
  logic [AW-1:0]          head_q, head_d, rd_q, rd_d, k_q, k_d, head_nxt;
  logic signed [ACCW-1:0] acc_q, acc_d, rnd, r;
  logic signed [DW+CW-1:0] prod;
  logic signed [DW-1:0]   audio_out_q, audio_out_d, sat_val;
  logic                   out_valid_q, out_valid_d, overrun_q, overrun_d;

  always_ff @(posedge rf_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (k_q == LAST) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding adds half an LSB before the arithmetic shift: ties go toward +inf.
  always_comb begin
    rnd = acc_q + HALF;
    r   = rnd >>> SHIFT;
  end

`ifdef CIC_COMP_FIR_SAT_EN
  always_comb begin
    if (r > OUT_MAX)      sat_val = OUT_MAX[DW-1:0];
    else if (r < OUT_MIN) sat_val = OUT_MIN[DW-1:0];
    else                  sat_val = r[DW-1:0];
  end
`else
  logic unused_r_hi;
  assign unused_r_hi = ^r[ACCW-1:DW];
  assign sat_val     = r[DW-1:0];
`endif

  always_comb begin
    x_d         = x_q;
    coef_d      = coef_q;
    head_d      = head_q;
    rd_d        = rd_q;
    k_d         = k_q;
    acc_d       = acc_q;
    audio_out_d = audio_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    head_nxt    = (head_q == LAST) ? '0 : head_q + AW'(1);
    prod        = x_q[rd_q] * coef_q[k_q];
    case (state_q)
      IDLE: begin
        if (coef_we && (coef_addr <= LAST)) coef_d[coef_addr] = coef_wdata;
        if (in_valid) begin
          x_d[head_nxt] = audio_in;
          head_d        = head_nxt;
          rd_d          = head_nxt;
          acc_d         = '0;
          k_d           = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
        k_d   = k_q + AW'(1);
        rd_d  = (rd_q == '0) ? LAST : rd_q - AW'(1);
        if (in_valid) overrun_d = 1'b1;
      end
      OUT: begin
        audio_out_d = sat_val;
        out_valid_d = 1'b1;
        if (in_valid) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rf_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= (i == 0) ? UNITY : '0;
      end
      head_q      <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      coef_q      <= coef_d;
      head_q      <= head_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: expected samples are queued at stimulus time
// and checked by a monitor whenever out_valid strobes.
module tb_cic_comp_fir;
  localparam int NTAPS = 15, AW = 4, DW = 16, CW = 18;

  logic                 rf_clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] audio_in = '0;
  logic                 in_valid = 1'b0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic signed [DW-1:0] audio_out;
  logic                 out_valid, busy, overrun;

  int n_cmp = 0, n_bad = 0, pulses = 0;
  logic signed [DW-1:0] exp_q[$];

  cic_comp_fir #(.NTAPS(NTAPS), .AW(AW), .DW(DW), .CW(CW)) dut (
    .rf_clk(rf_clk), .reset(reset), .audio_in(audio_in), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .audio_out(audio_out), .out_valid(out_valid), .busy(busy), .overrun(overrun));

  always #5 rf_clk = ~rf_clk;

  always @(negedge rf_clk) begin
    if (!reset && out_valid) begin
      logic signed [DW-1:0] e;
      pulses++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: audio_out=%0d with no expected sample queued", audio_out);
      end else begin
        e = exp_q.pop_front();
        if (audio_out !== e) begin
          n_bad++;
          $display("FAIL sample: audio_out=%0d expected=%0d", audio_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge rf_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic send(input int v, input bit expect_out, input int e);
    audio_in = DW'(v);
    in_valid = 1'b1;
    if (expect_out) exp_q.push_back(DW'(e));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_addr = AW'(a);
    coef_wdata = CW'(d);
    coef_we = 1'b1;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    tick();
    n_cmp++;
    if (n >= 200) begin
      n_bad++;
      $display("FAIL %s_timeout: queue=%0d busy=%0b required empty/idle", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (audio_out !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: out=%0d ov=%0b busy=%0b overrun=%0b required 0/0/0/0",
               audio_out, out_valid, busy, overrun);
    end
    send(1234, 1'b1, 1234);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept: busy=%0b required 1", busy); end
    for (int i = 0; i < NTAPS; i++) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early: out_valid=%0b required 0", out_valid); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL latency: out_valid=%0b busy=%0b required 1/0 at 16 clocks", out_valid, busy);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || audio_out !== 16'sd1234) begin
      n_bad++;
      $display("FAIL strobe_width: out_valid=%0b busy=%0b out=%0d required 0/0/1234", out_valid, busy, audio_out);
    end
    wait_idle("reset");
  endtask

  task automatic test_four_tap();
    int s[4] = '{4000, 8000, -4000, 0};
    int e[4] = '{1000, 3000, 2000, 2000};
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(i, 16384);
    for (int i = 0; i < 4; i++) begin
      send(s[i], 1'b1, e[i]);
      for (int j = 0; j < 39; j++) tick();
    end
    wait_idle("four_tap");
  endtask

  task automatic test_rounding();
    int s[4] = '{-1, 1, -3, 3};
    int e[4] = '{0, 1, -1, 2};
    do_reset();
    write_coef(0, 32768);
    for (int i = 0; i < 4; i++) begin
      send(s[i], 1'b1, e[i]);
      wait_idle("rounding");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    write_coef(0, 131071);
`ifdef CIC_COMP_FIR_SAT_EN
    send(30000, 1'b1, 32767);
    wait_idle("sat_hi");
    send(-30000, 1'b1, -32768);
`else
    send(30000, 1'b1, -5536);
    wait_idle("sat_hi");
    send(-30000, 1'b1, 5536);
`endif
    wait_idle("sat_lo");
  endtask

  task automatic test_overrun();
    int p0;
    do_reset();
    p0 = pulses;
    send(100, 1'b1, 100);
    for (int i = 0; i < 4; i++) tick();
    send(200, 1'b0, 0);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: overrun=%0b required 1", overrun); end
    wait_idle("overrun");
    n_cmp++;
    if (pulses - p0 !== 1) begin n_bad++; $display("FAIL overrun_pulses: got %0d strobes required 1", pulses - p0); end
    send(300, 1'b1, 300);
    wait_idle("overrun_next");
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: overrun=%0b required 1", overrun); end
  endtask

  task automatic test_coef_busy();
    do_reset();
    send(500, 1'b1, 500);
    tick();
    write_coef(0, 0);
    wait_idle("coef_busy");
    send(600, 1'b1, 600);
    wait_idle("coef_busy_next");
    write_coef(15, 0);
    send(700, 1'b1, 700);
    wait_idle("coef_addr_oob");
  endtask

  task automatic test_same_edge();
    do_reset();
    audio_in = 16'sd1000;
    in_valid = 1'b1;
    coef_addr = '0;
    coef_wdata = CW'(32768);
    coef_we = 1'b1;
    exp_q.push_back(16'sd500);
    tick();
    in_valid = 1'b0;
    coef_we = 1'b0;
    wait_idle("same_edge");
  endtask

  task automatic test_reset_mid_mac();
    int p0;
    do_reset();
    write_coef(0, 0);
    write_coef(3, 65536);
    send(2222, 1'b1, 0);
    wait_idle("prefill");
    p0 = pulses;
    send(999, 1'b0, 0);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    n_cmp++;
    if (pulses !== p0 || audio_out !== 16'sd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_mac: strobes=%0d out=%0d busy=%0b required 0/0/0", pulses - p0, audio_out, busy);
    end
    send(77, 1'b1, 77);
    wait_idle("after_abort");
  endtask

  initial begin
    test_reset();
    test_four_tap();
    test_rounding();
    test_saturation();
    test_overrun();
    test_coef_busy();
    test_same_edge();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
